// File: rtl/detector_jogada.sv
// detector_jogada -- input conditioning for the memory game.
//   Synchronises the four raw player buttons (two flops), debounces them and
//   turns every stable press into exactly one registered jogada code plus a
//   one-cycle jogada_feita strobe. The button pattern must be released before
//   another press can be accepted.
//
// Parameters
//   DEBOUNCE_CICLOS  consecutive equal synced samples to accept press/release (>=1)
//   TIMEOUT_CICLOS   idle cycles in ESPERA before timeout (timeout build only)
//
// Optional feature: define DETECTOR_JOGADA_TIMEOUT_EN to enable the inactivity
// timeout strobe; otherwise timeout is tied to 0.
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high
//   habilita         in   1 = game is waiting for a move
//   limpa            in   synchronous clear of the jogada register
//   botoes[3:0]      in   raw asynchronous buttons, active-high
//   jogada[3:0]      out  last accepted pattern (multi-bit patterns kept as-is)
//   jogada_feita     out  one-cycle strobe, new jogada valid
//   jogada_invalida  out  one-cycle strobe with jogada_feita when >1 bit set
//   timeout          out  one-cycle inactivity strobe
//   db_estado[2:0]   out  FSM state code (ESPERA=0 FILTRA=1 EMITE=2 SOLTA=3)
module detector_jogada #(
  parameter int unsigned DEBOUNCE_CICLOS = 2,
  parameter int unsigned TIMEOUT_CICLOS  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       limpa,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [2:0] db_estado
);

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CNT_W:0] DEB_LIM = (CNT_W + 1)'(DEBOUNCE_CICLOS);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    FILTRA = 2'd1,
    EMITE  = 2'd2,
    SOLTA  = 2'd3
  } estado_t;

  estado_t          r_estado, w_estado_prox;
  logic [3:0]       r_s1, r_s2;
  logic [3:0]       r_ref, w_ref_prox;
  logic [3:0]       r_jogada, w_jogada_prox;
  logic [CNT_W-1:0] r_cnt, w_cnt_prox;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_cnt_fim;
  logic [CNT_W-1:0] w_cnt_sat;

  // Counter increment is computed one bit wider so the limit compare cannot
  // wrap; the stored value saturates at DEBOUNCE_CICLOS.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_cnt_fim = (w_cnt_inc >= DEB_LIM);
  assign w_cnt_sat = w_cnt_fim ? CNT_W'(DEBOUNCE_CICLOS) : w_cnt_inc[CNT_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= botoes;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ESPERA;
      r_ref    <= '0;
      r_cnt    <= '0;
      r_jogada <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_ref    <= w_ref_prox;
      r_cnt    <= w_cnt_prox;
      r_jogada <= w_jogada_prox;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_ref_prox    = r_ref;
    w_cnt_prox    = r_cnt;
    // limpa clears the register unless the EMITE load below overrides it.
    w_jogada_prox = limpa ? '0 : r_jogada;

    case (r_estado)
      ESPERA: begin
        if (!habilita) begin
          w_estado_prox = SOLTA;
          w_cnt_prox    = '0;
        end else if (r_s2 != '0) begin
          w_estado_prox = FILTRA;
          w_ref_prox    = r_s2;
          w_cnt_prox    = CNT_W'(1);
        end
      end
      FILTRA: begin
        if (!habilita) begin
          w_estado_prox = SOLTA;
          w_cnt_prox    = '0;
        end else if (r_s2 == '0) begin
          w_estado_prox = ESPERA;
          w_cnt_prox    = '0;
        end else if (r_s2 != r_ref) begin
          w_ref_prox = r_s2;
          w_cnt_prox = CNT_W'(1);
        end else begin
          w_cnt_prox = w_cnt_sat;
          if (w_cnt_fim) begin
            w_estado_prox = EMITE;
            w_jogada_prox = r_ref;
          end
        end
      end
      EMITE: begin
        w_estado_prox = SOLTA;
        w_cnt_prox    = '0;
      end
      SOLTA: begin
        // Any non-zero pattern restarts the release count, so changes while
        // held never produce another strobe.
        if (r_s2 != '0) begin
          w_cnt_prox = '0;
        end else if (w_cnt_fim) begin
          w_estado_prox = ESPERA;
          w_cnt_prox    = '0;
        end else begin
          w_cnt_prox = w_cnt_sat;
        end
      end
      default: begin
        w_estado_prox = ESPERA;
        w_cnt_prox    = '0;
      end
    endcase
  end

  assign jogada          = r_jogada;
  assign jogada_feita    = (r_estado == EMITE);
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign jogada_invalida = jogada_feita && ((r_jogada & (r_jogada - 4'd1)) != 4'd0);
  assign db_estado       = {1'b0, r_estado};

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
  localparam int unsigned   TO_W     = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT_CICLOS);
  localparam logic [TO_W-1:0] TO_ANTES = TO_W'(TIMEOUT_CICLOS - 1);

  logic [TO_W-1:0] r_ocioso;
  logic            r_timeout;
  logic            w_aguardando;

  assign w_aguardando = (r_estado == ESPERA) && habilita;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ocioso  <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Strobe on the edge the counter reaches the limit; it then holds there.
      r_timeout <= w_aguardando && (r_ocioso == TO_ANTES);
      if (!w_aguardando) begin
        r_ocioso <= '0;
      end else if (r_ocioso != TO_LIM) begin
        r_ocioso <= r_ocioso + TO_W'(1);
      end
    end
  end

  assign timeout = r_timeout;
`else
  // TIMEOUT_CICLOS stays in the parameter list so both builds share one interface.
  assign timeout = 1'b0 & (TIMEOUT_CICLOS == 0);
`endif

endmodule
